dcache_flush_ctrl: RTL and testbench

Flush sequencer for the std data cache management port. Collects level-sensitive flush requests from several requesters (e.g. fence, fence.i, CSR cache disable). Waits for the write buffer to drain, then drives the cache's flush handshake. Acknowledges every coalesced requester with a one-cycle pulse. Sits between the core's flush sources and the cache's `dcache_flush` / `dcache_flush_ack` management signals.

---
 rtl/dcache_flush_ctrl.sv | 114 +++++++++++
 tb/tb_dcache_flush_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_flush_ctrl.sv
// Flush sequencer: coalesces level flush requests, waits for the write buffer to drain, then
// drives the cache flush handshake. Optional start watchdog under DCACHE_FLUSH_TIMEOUT_EN.
module dcache_flush_ctrl #(
    parameter int unsigned NR_REQ         = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NR_REQ-1:0] flush_req_i,
    output logic [NR_REQ-1:0] flush_ack_o,
    input  logic              wbuffer_empty_i,
    output logic              dcache_flush_o,
    input  logic              dcache_flushing_i,
    input  logic              dcache_flush_ack_i,
    output logic              busy_o,
    output logic [15:0]       flush_cnt_o,
    output logic              timeout_o
);

    if (NR_REQ < 1 || NR_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("dcache_flush_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {StIdle, StDrain, StFlush, StAck} state_e;

    state_e            state_q, state_d;
    logic [NR_REQ-1:0] pend_q, pend_d;
    logic [15:0]       cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|flush_req_i) begin
                    pend_d  = flush_req_i;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (wbuffer_empty_i) state_d = StFlush;
            end
            StFlush: begin
                if (dcache_flush_ack_i) state_d = StAck;
            end
            StAck: begin
                pend_d  = '0;
                state_d = StIdle;
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef DCACHE_FLUSH_TIMEOUT_EN
    localparam logic [15:0] WdLimit = 16'(TIMEOUT_CYCLES - 1);

    logic        started_q, started_d;
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        started_d = started_q;
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (state_q == StDrain && wbuffer_empty_i) begin
            started_d = 1'b0;
            wd_cnt_d  = '0;
        end else if (state_q == StFlush) begin
            if (dcache_flushing_i) started_d = 1'b1;
            // Counting stops for good once the cache has shown any sign of starting.
            if (!started_q && !dcache_flushing_i) begin
                if (wd_cnt_q == WdLimit) timeout_d = 1'b1;
                else                     wd_cnt_d  = wd_cnt_q + 16'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            pend_q    <= '0;
            cnt_q     <= '0;
`ifdef DCACHE_FLUSH_TIMEOUT_EN
            started_q <= 1'b0;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
`ifdef DCACHE_FLUSH_TIMEOUT_EN
            started_q <= started_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Every output is decoded from registers only.
    assign dcache_flush_o = (state_q == StFlush);
    assign flush_ack_o    = (state_q == StAck) ? pend_q : '0;
    assign busy_o         = (state_q != StIdle);
    assign flush_cnt_o    = cnt_q;
`ifdef DCACHE_FLUSH_TIMEOUT_EN
    assign timeout_o      = timeout_q;
`else
    assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Directed self-checking bench for dcache_flush_ctrl (NR_REQ=3, TIMEOUT_CYCLES=8).
module tb_dcache_flush_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  ack;
    logic        wbuf;
    logic        dflush;
    logic        flushing;
    logic        dack;
    logic        busy;
    logic [15:0] cnt;
    logic        timeout;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef DCACHE_FLUSH_TIMEOUT_EN
    localparam logic ExpTo = 1'b1;
`else
    localparam logic ExpTo = 1'b0;
`endif

    dcache_flush_ctrl #(.NR_REQ(3), .TIMEOUT_CYCLES(8)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .flush_req_i        (req),
        .flush_ack_o        (ack),
        .wbuffer_empty_i    (wbuf),
        .dcache_flush_o     (dflush),
        .dcache_flushing_i  (flushing),
        .dcache_flush_ack_i (dack),
        .busy_o             (busy),
        .flush_cnt_o        (cnt),
        .timeout_o          (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req = '0; wbuf = 1'b0; flushing = 1'b0; dack = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // Stimulus only: one minimum-latency round for the given mask, ending in the cycle after ACK.
    task automatic do_round(input logic [2:0] mask);
        req = mask; wbuf = 1'b1;
        step();
        step();
        dack = 1'b1;
        step();
        dack = 1'b0; req = '0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; wbuf = 1'b0; flushing = 1'b0; dack = 1'b0;
        #3;
        if ({ack, dflush, busy, cnt, timeout} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ack=%b flush=%b busy=%b cnt=%h to=%b want all 0",
                     ack, dflush, busy, cnt, timeout);
        end
        n_cmp++;
        apply_reset();
    endtask

    task automatic test_single();
        logic [2:0] exp_ack [5] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
        logic       exp_fl  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       exp_bz  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        apply_reset();
        req = 3'b001; wbuf = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if ({ack, dflush, busy} !== {exp_ack[c], exp_fl[c], exp_bz[c]}) begin
                n_bad++;
                $display("FAIL single_c%0d: got ack=%b flush=%b busy=%b want ack=%b flush=%b busy=%b",
                         c, ack, dflush, busy, exp_ack[c], exp_fl[c], exp_bz[c]);
            end
            n_cmp++;
            dack = (c == 2);
            if (c == 3) req = '0;
            step();
            if (c == 3) begin
                if (cnt !== 16'd1) begin
                    n_bad++;
                    $display("FAIL single_cnt: got %0d want 1", cnt);
                end
                n_cmp++;
            end
        end
    endtask

    task automatic test_coalesce();
        apply_reset();
        req = 3'b101; wbuf = 1'b1;
        step(); step();
        req = 3'b111; dack = 1'b1;
        step();
        dack = 1'b0;
        if (ack !== 3'b101) begin
            n_bad++;
            $display("FAIL coalesce_first: got ack=%b want 101", ack);
        end
        n_cmp++;
        req = 3'b010;
        step();
        if ({busy, ack} !== 4'b0000) begin
            n_bad++;
            $display("FAIL coalesce_idle: got busy=%b ack=%b want 0 000", busy, ack);
        end
        n_cmp++;
        step();
        step();
        dack = 1'b1;
        step();
        dack = 1'b0;
        if (ack !== 3'b010) begin
            n_bad++;
            $display("FAIL coalesce_second: got ack=%b want 010", ack);
        end
        n_cmp++;
        req = '0;
        step();
        if (cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL coalesce_cnt: got %0d want 2", cnt);
        end
        n_cmp++;
    endtask

    task automatic test_drain_stall();
        apply_reset();
        req = 3'b001; wbuf = 1'b0;
        step();
        for (int c = 0; c < 10; c++) begin
            if ({dflush, busy} !== 2'b01) begin
                n_bad++;
                $display("FAIL stall_c%0d: got flush=%b busy=%b want 0 1", c, dflush, busy);
            end
            n_cmp++;
            step();
        end
        wbuf = 1'b1;
        if (dflush !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_release: got flush=%b want 0", dflush);
        end
        n_cmp++;
        step();
        if (dflush !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_rise: got flush=%b want 1", dflush);
        end
        n_cmp++;
        dack = 1'b1;
        step();
        dack = 1'b0; req = '0;
        if ({dflush, ack} !== 4'b0001) begin
            n_bad++;
            $display("FAIL stall_ack: got flush=%b ack=%b want 0 001", dflush, ack);
        end
        n_cmp++;
        step();
    endtask

    task automatic test_watchdog();
        apply_reset();
        req = 3'b001; wbuf = 1'b1;
        step(); step();
        for (int c = 0; c < 8; c++) begin
            if ({dflush, timeout} !== 2'b10) begin
                n_bad++;
                $display("FAIL wd_pre%0d: got flush=%b timeout=%b want 1 0", c, dflush, timeout);
            end
            n_cmp++;
            step();
        end
        if ({dflush, timeout} !== {1'b1, ExpTo}) begin
            n_bad++;
            $display("FAIL wd_fire: got flush=%b timeout=%b want 1 %b", dflush, timeout, ExpTo);
        end
        n_cmp++;
        step();
        dack = 1'b1;
        step();
        dack = 1'b0;
        if ({ack, timeout} !== {3'b001, ExpTo}) begin
            n_bad++;
            $display("FAIL wd_ack: got ack=%b timeout=%b want 001 %b", ack, timeout, ExpTo);
        end
        n_cmp++;
        req = '0;
        step();
        if ({cnt, timeout} !== {16'd1, ExpTo}) begin
            n_bad++;
            $display("FAIL wd_after: got cnt=%0d timeout=%b want 1 %b", cnt, timeout, ExpTo);
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid_flush();
        logic saw_ack = 1'b0;
        apply_reset();
        do_round(3'b100);
        req = 3'b001; wbuf = 1'b1;
        step(); step();
        if (dflush !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre: got flush=%b want 1", dflush);
        end
        n_cmp++;
        #2 rst_n = 1'b0;
        #1;
        if ({ack, dflush, busy, cnt, timeout} !== 22'd0) begin
            n_bad++;
            $display("FAIL rst_async: got ack=%b flush=%b busy=%b cnt=%h to=%b want all 0",
                     ack, dflush, busy, cnt, timeout);
        end
        n_cmp++;
        dack = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            if (ack !== 3'b000) saw_ack = 1'b1;
        end
        dack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        if ({busy, dflush} !== 2'b10) begin
            n_bad++;
            $display("FAIL rst_recapture: got busy=%b flush=%b want 1 0", busy, dflush);
        end
        n_cmp++;
        step();
        dack = 1'b1;
        step();
        dack = 1'b0;
        if ({saw_ack, ack} !== 4'b0001) begin
            n_bad++;
            $display("FAIL rst_rerun_ack: got stray=%b ack=%b want 0 001", saw_ack, ack);
        end
        n_cmp++;
        req = '0;
        step();
        if (cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL rst_cnt: got %0d want 1", cnt);
        end
        n_cmp++;
    endtask

    task automatic test_saturation();
        apply_reset();
        force dut.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_q;
        step();
        if (cnt !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL sat_preload: got %h want fffe", cnt);
        end
        n_cmp++;
        do_round(3'b010);
        if (cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_reach: got %h want ffff", cnt);
        end
        n_cmp++;
        do_round(3'b010);
        if (cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_hold: got %h want ffff", cnt);
        end
        n_cmp++;
        dack = 1'b1;
        step();
        dack = 1'b0;
        step();
        if ({ack, dflush, busy, cnt} !== {3'b000, 1'b0, 1'b0, 16'hFFFF}) begin
            n_bad++;
            $display("FAIL spurious_ack: got ack=%b flush=%b busy=%b cnt=%h want 000 0 0 ffff",
                     ack, dflush, busy, cnt);
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_coalesce();
        test_drain_stall();
        test_watchdog();
        test_reset_mid_flush();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
